control_sequencer: RTL

Microcoded control unit for the 8-bit SAP-style bus computer. It steps through a fixed five-T-state fetch/execute cycle and decodes the 4-bit opcode from the instruction register. It drives every register's load strobe and every tri-state bus enable, including the accumulator's active-low load and active-high output enable. It sits upstream of all datapath registers and is the only source of control for the shared 8-bit bus.

---
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the SAP sequencer and the datapath it steers.
// Carries the opcode/flag inputs and every load strobe, bus enable and status output.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  // Datapath status into the sequencer
  logic [3:0] opcode;
  logic       carry;
  logic       zero;

  // Program counter
  logic       ep;
  logic       cp;
  logic       lp_n;

  // Memory address register and RAM
  logic       lm_n;
  logic       em;
  logic       wr;

  // Instruction register
  logic       li_n;
  logic       ei;

  // Accumulator, B register, ALU, flags
  logic       la_n;
  logic       ea;
  logic       lb_n;
  logic       eu;
  logic       su;
  logic       lf_n;

  // Output register and status
  logic       lo_n;
  logic       hlt;
  logic [2:0] tstate;

  modport master (
    input  opcode, carry, zero,
    output ep, cp, lp_n, lm_n, em, wr, li_n, ei,
           la_n, ea, lb_n, eu, su, lf_n, lo_n, hlt, tstate
  );

  modport slave (
    output opcode, carry, zero,
    input  ep, cp, lp_n, lm_n, em, wr, li_n, ei,
           la_n, ea, lb_n, eu, su, lf_n, lo_n, hlt, tstate
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded T1..T5 control unit for the 8-bit SAP bus computer.
// Latency: one T-state per clock; outputs are combinational from state, opcode and flags.
// No backpressure: the sequence free-runs until HLT, and only rst leaves HALT.
module control_sequencer (
  input  logic                       clk,
  input  logic                       rst,
  control_sequencer_if.master        ctl_if
);

  // Ring states plus the terminal HALT state
  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Control word held in active-high sense; polarity is fixed up at the ports
  typedef struct packed {
    logic ep;   // PC -> bus
    logic cp;   // PC increment
    logic lp;   // PC <- bus
    logic lm;   // MAR <- bus
    logic em;   // RAM -> bus
    logic wr;   // RAM write
    logic li;   // IR <- bus
    logic ei;   // IR low nibble -> bus
    logic la;   // A <- bus
    logic ea;   // A -> bus
    logic lb;   // B <- bus
    logic eu;   // ALU -> bus
    logic su;   // ALU subtract
    logic lf;   // flags capture
    logic lo;   // OUT <- bus
    logic hlt;  // halted
  } ctrl_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     r_state;
  state_t     w_next_state;
  ctrl_t      w_ctrl;
  ctrl_t      w_act;
  logic [2:0] w_tstate;

  // State register: reset forces T1 immediately, independent of the clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_T1;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: fixed five-step ring, with HLT diverting to HALT at the end of T3
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_T1:    w_next_state = S_T2;
      S_T2:    w_next_state = S_T3;
      S_T3:    w_next_state = (ctl_if.opcode == OP_HLT) ? S_HALT : S_T4;
      S_T4:    w_next_state = S_T5;
      S_T5:    w_next_state = S_T1;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_T1;
    endcase
  end

  // Microcode decode: fetch is opcode-independent, execute looks at opcode/flags
  always_comb begin
    w_ctrl = '0;
    unique case (r_state)
      S_T1: begin
        w_ctrl.ep = 1'b1;
        w_ctrl.lm = 1'b1;
      end

      S_T2: begin
        w_ctrl.em = 1'b1;
        w_ctrl.li = 1'b1;
        w_ctrl.cp = 1'b1;
      end

      S_T3: begin
        case (ctl_if.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_ctrl.ei = 1'b1;
            w_ctrl.lm = 1'b1;
          end
          OP_LDI: begin
            w_ctrl.ei = 1'b1;
            w_ctrl.la = 1'b1;
          end
          OP_JMP: begin
            w_ctrl.ei = 1'b1;
            w_ctrl.lp = 1'b1;
          end
          // Conditional jumps: the target is always on the bus, only the load is gated
          OP_JC: begin
            w_ctrl.ei = 1'b1;
            w_ctrl.lp = ctl_if.carry;
          end
          OP_JZ: begin
            w_ctrl.ei = 1'b1;
            w_ctrl.lp = ctl_if.zero;
          end
          OP_OUT: begin
            w_ctrl.ea = 1'b1;
            w_ctrl.lo = 1'b1;
          end
          OP_HLT: begin
            w_ctrl.hlt = 1'b1;
          end
          default: begin
            w_ctrl = '0;
          end
        endcase
      end

      S_T4: begin
        case (ctl_if.opcode)
          OP_LDA: begin
            w_ctrl.em = 1'b1;
            w_ctrl.la = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_ctrl.em = 1'b1;
            w_ctrl.lb = 1'b1;
          end
          OP_STA: begin
            w_ctrl.ea = 1'b1;
            w_ctrl.wr = 1'b1;
          end
          default: begin
            w_ctrl = '0;
          end
        endcase
      end

      S_T5: begin
        case (ctl_if.opcode)
          OP_ADD, OP_SUB: begin
            w_ctrl.eu = 1'b1;
            w_ctrl.la = 1'b1;
            w_ctrl.lf = 1'b1;
            w_ctrl.su = (ctl_if.opcode == OP_SUB);
          end
          default: begin
            w_ctrl = '0;
          end
        endcase
      end

      // Opcode and flags are deliberately ignored once halted
      S_HALT: begin
        w_ctrl.hlt = 1'b1;
      end

      default: begin
        w_ctrl = '0;
      end
    endcase
  end

  // Reset gating: outputs go inactive the moment rst rises, and T1 drives appear as it falls
  always_comb begin
    w_act    = rst ? '0 : w_ctrl;
    w_tstate = 3'd1;
    if (!rst) begin
      unique case (r_state)
        S_T1:    w_tstate = 3'd1;
        S_T2:    w_tstate = 3'd2;
        S_T3:    w_tstate = 3'd3;
        S_T4:    w_tstate = 3'd4;
        S_T5:    w_tstate = 3'd5;
        S_HALT:  w_tstate = 3'd0;
        default: w_tstate = 3'd1;
      endcase
    end
  end

  // Port mapping with the datapath's native strobe polarities
  assign ctl_if.ep     =  w_act.ep;
  assign ctl_if.cp     =  w_act.cp;
  assign ctl_if.lp_n   = ~w_act.lp;
  assign ctl_if.lm_n   = ~w_act.lm;
  assign ctl_if.em     =  w_act.em;
  assign ctl_if.wr     =  w_act.wr;
  assign ctl_if.li_n   = ~w_act.li;
  assign ctl_if.ei     =  w_act.ei;
  assign ctl_if.la_n   = ~w_act.la;
  assign ctl_if.ea     =  w_act.ea;
  assign ctl_if.lb_n   = ~w_act.lb;
  assign ctl_if.eu     =  w_act.eu;
  assign ctl_if.su     =  w_act.su;
  assign ctl_if.lf_n   = ~w_act.lf;
  assign ctl_if.lo_n   = ~w_act.lo;
  assign ctl_if.hlt    =  w_act.hlt;
  assign ctl_if.tstate =  w_tstate;

endmodule
